cacheline_adaptor: RTL and testbench

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cacheline_adaptor_if.sv | 30 +++
 rtl/cacheline_adaptor.sv | 101 ++++++++++
 tb/tb_cacheline_adaptor.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_if.sv
// Cache-side line port and memory-side burst port of the cacheline adaptor.
// The adaptor uses the slave view; whoever drives the requests uses the master view.
interface cacheline_adaptor_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned BEAT_W = 64;

  logic [ADDR_W-1:0] address_i;
  logic [LINE_W-1:0] line_i;
  logic [LINE_W-1:0] line_o;
  logic              read_i;
  logic              write_i;
  logic              resp_o;
  logic [ADDR_W-1:0] address_o;
  logic [BEAT_W-1:0] burst_i;
  logic [BEAT_W-1:0] burst_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i;

  modport slave (
    input  address_i, line_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, address_o, burst_o, read_o, write_o
  );

  modport master (
    output address_i, line_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, burst_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts 256-bit cache line reads/writes into 4-beat 64-bit memory bursts.
// Every output comes straight from a flop; next values are computed from the next state.
module cacheline_adaptor (
  input  logic                clk,
  input  logic                rst,
  cacheline_adaptor_if.slave  bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                        state, state_d;
  logic [CNT_W-1:0]              cnt, cnt_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [BEATS-1:0][BEAT_W-1:0]  wline_q, wline_d;
  logic [BEATS-1:0][BEAT_W-1:0]  rline_q, rline_d;
  logic [BEAT_W-1:0]             burst_q, burst_d;
  logic                          read_q, read_d;
  logic                          write_q, write_d;
  logic                          resp_q, resp_d;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      burst_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      burst_q <= burst_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  // Next state, beat sequencing and next output values
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;

    unique case (state)
      IDLE: begin
        // A simultaneous read and write request is served as a read
        if (bus.read_i) begin
          addr_d  = bus.address_i & ~ADDR_W'(32'h1F);
          cnt_d   = '0;
          state_d = READ;
        end else if (bus.write_i) begin
          addr_d  = bus.address_i & ~ADDR_W'(32'h1F);
          wline_d = bus.line_i;
          cnt_d   = '0;
          state_d = WRITE;
        end
      end
      READ: begin
        if (bus.resp_i) begin
          rline_d[cnt] = bus.burst_i;
          cnt_d        = cnt + CNT_W'(1);
          if (cnt == CNT_W'(BEATS - 1)) state_d = DONE;
        end
      end
      WRITE: begin
        if (bus.resp_i) begin
          cnt_d = cnt + CNT_W'(1);
          if (cnt == CNT_W'(BEATS - 1)) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    read_d  = (state_d == READ);
    write_d = (state_d == WRITE);
    resp_d  = (state_d == DONE);
    burst_d = wline_d[cnt_d];
  end

  assign bus.address_o = addr_q;
  assign bus.line_o    = rline_q;
  assign bus.burst_o   = burst_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_cacheline_adaptor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_adaptor_if ifc();
  cacheline_adaptor dut (.clk(clk), .rst(rst), .bus(ifc));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: pending kind (0 none, 1 read, 2 write), beats moved so far
  int            m_kind;
  int            m_beats;
  bit            m_done;
  logic [31:0]   m_addr;
  logic [63:0]   m_wb [4];
  logic [255:0]  m_line;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_kind = 0; m_beats = 0; m_done = 0; m_addr = '0; m_line = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_kind == 0) begin
      if (ifc.read_i || ifc.write_i) begin
        m_kind  = ifc.read_i ? 1 : 2;
        m_beats = 0;
        m_addr  = ifc.address_i & 32'hFFFF_FFE0;
        if (m_kind == 2)
          for (int i = 0; i < 4; i++) m_wb[i] = ifc.line_i[64*i +: 64];
      end
    end else if (ifc.resp_i) begin
      if (m_kind == 1) m_line[64*m_beats +: 64] = ifc.burst_i;
      m_beats++;
      if (m_beats == 4) begin
        m_kind = 0;
        m_done = 1;
      end
    end
  end

  // Per-cycle comparison against the model, just after each rising edge
  always @(posedge clk) begin
    #1;
    chk("read_o",    256'(ifc.read_o),    256'(m_kind == 1));
    chk("write_o",   256'(ifc.write_o),   256'(m_kind == 2));
    chk("resp_o",    256'(ifc.resp_o),    256'(m_done));
    chk("address_o", 256'(ifc.address_o), 256'(m_addr));
    chk("line_o",    ifc.line_o,          m_line);
    if (m_kind == 2) chk("burst_o", 256'(ifc.burst_o), 256'(m_wb[m_beats]));
  end

  localparam logic [255:0] EXP_RD = {{8{8'hA3}}, {8{8'hA2}}, {8{8'hA1}}, {8{8'hA0}}};
  localparam logic [255:0] WR_LINE = {{8{8'hD3}}, {8{8'hD2}}, {8{8'hD1}}, {8{8'hD0}}};

  initial begin
    logic [63:0] first_beat;
    bit          pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    ifc.read_i = 1'b0; ifc.write_i = 1'b0; ifc.address_i = '0;
    ifc.line_i = '0; ifc.burst_i = '0; ifc.resp_i = 1'b0;
    #2;
    chk("rst_read_o", 256'(ifc.read_o), 256'(0));
    chk("rst_resp_o", 256'(ifc.resp_o), 256'(0));
    chk("rst_line_o", ifc.line_o, 256'(0));
    chk("rst_addr_o", 256'(ifc.address_o), 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Continuous read, requested in the first cycle out of reset
    ifc.read_i = 1'b1; ifc.address_i = 32'h1234_5678; ifc.resp_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ifc.read_i  = 1'b0;
      ifc.burst_i = {8{8'hA0 + 8'(k)}};
      chk("rd_read_o", 256'(ifc.read_o), 256'(1));
      chk("rd_addr_o", 256'(ifc.address_o), 256'(32'h1234_5660));
    end
    @(negedge clk);
    chk("rd_resp_c5", 256'(ifc.resp_o), 256'(1));
    chk("rd_read_c5", 256'(ifc.read_o), 256'(0));
    chk("rd_line", ifc.line_o, EXP_RD);
    ifc.resp_i = 1'b0;

    // Continuous write; line_o must keep the read data
    @(negedge clk);
    ifc.write_i = 1'b1; ifc.line_i = WR_LINE; ifc.address_i = 32'hCAFE_0047; ifc.resp_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ifc.write_i = 1'b0;
      chk("wr_write_o", 256'(ifc.write_o), 256'(1));
      chk("wr_burst_o", 256'(ifc.burst_o), 256'({8{8'hD0 + 8'(k)}}));
    end
    @(negedge clk);
    chk("wr_resp_c5", 256'(ifc.resp_o), 256'(1));
    chk("wr_line_kept", ifc.line_o, EXP_RD);
    chk("wr_addr_o", 256'(ifc.address_o), 256'(32'hCAFE_0040));
    ifc.resp_i = 1'b0;

    // Read with stalls: resp_i 1,0,0,1,1,0,1
    @(negedge clk);
    ifc.read_i = 1'b1; ifc.address_i = $urandom;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      ifc.read_i  = 1'b0;
      ifc.resp_i  = pat[c];
      ifc.burst_i = {$urandom, $urandom};
      chk("stall_read_o", 256'(ifc.read_o), 256'(1));
    end
    @(negedge clk);
    ifc.resp_i = 1'b0;
    chk("stall_resp_c8", 256'(ifc.resp_o), 256'(1));

    // Read and write together: served as a read
    @(negedge clk);
    ifc.read_i = 1'b1; ifc.write_i = 1'b1; ifc.resp_i = 1'b1; ifc.line_i = {8{$urandom}};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ifc.read_i = 1'b0; ifc.write_i = 1'b0;
      ifc.burst_i = {$urandom, $urandom};
      chk("both_read_o", 256'(ifc.read_o), 256'(1));
      chk("both_write_o", 256'(ifc.write_o), 256'(0));
    end
    @(negedge clk);
    chk("both_resp", 256'(ifc.resp_o), 256'(1));

    // Reset after two read beats, then a write from beat 0
    @(negedge clk);
    ifc.read_i = 1'b1; ifc.resp_i = 1'b1; ifc.address_i = $urandom;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ifc.read_i = 1'b0;
      ifc.burst_i = {$urandom, $urandom};
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_read_o", 256'(ifc.read_o), 256'(0));
    chk("mid_rst_resp_o", 256'(ifc.resp_o), 256'(0));
    chk("mid_rst_line_o", ifc.line_o, 256'(0));
    chk("mid_rst_addr_o", 256'(ifc.address_o), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    ifc.write_i = 1'b1; ifc.line_i = {8{$urandom}};
    first_beat = ifc.line_i[63:0];
    @(negedge clk);
    ifc.write_i = 1'b0;
    chk("post_rst_beat0", 256'(ifc.burst_o), 256'(first_beat));
    repeat (4) @(negedge clk);
    chk("post_rst_resp", 256'(ifc.resp_o), 256'(1));

    // Back-to-back reads with read_i held through DONE and stray resp_i in IDLE
    @(negedge clk);
    ifc.read_i = 1'b1; ifc.resp_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ifc.burst_i = {$urandom, $urandom};
    end
    @(negedge clk);
    chk("b2b_resp_c5", 256'(ifc.resp_o), 256'(1));
    @(negedge clk);
    chk("b2b_idle_resp", 256'(ifc.resp_o), 256'(0));
    chk("b2b_idle_read", 256'(ifc.read_o), 256'(0));
    @(negedge clk);
    ifc.read_i = 1'b0;
    chk("b2b_second_read", 256'(ifc.read_o), 256'(1));
    repeat (5) @(negedge clk);
    ifc.resp_i = 1'b0;

    // Randomized traffic, including request drops, stalls and rare resets
    repeat (3000) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(199) == 0) rst = 1'b1;
      ifc.read_i    = ($urandom_range(3) == 0);
      ifc.write_i   = ($urandom_range(2) == 0);
      ifc.address_i = $urandom;
      ifc.line_i    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ifc.burst_i   = {$urandom, $urandom};
      ifc.resp_i    = ($urandom_range(9) < 7);
    end
    @(negedge clk);
    rst = 1'b0;
    ifc.read_i = 1'b0; ifc.write_i = 1'b0; ifc.resp_i = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
